// File: rtl/rect_motion_ctrl_pkg.sv
// Shared VGA timing constants, configuration address codes and FSM encodings
// for the bouncing-rectangle controller.
package rect_motion_ctrl_pkg;

  localparam int unsigned HActiveDef = 640;
  localparam int unsigned VActiveDef = 480;
  localparam int unsigned HTotal     = 800;
  localparam int unsigned VTotal     = 525;

  typedef enum logic [1:0] {
    CfgW     = 2'd0,
    CfgH     = 2'd1,
    CfgSpeed = 2'd2,
    CfgPos   = 2'd3
  } cfg_addr_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StMoveX  = 2'd1,
    StMoveY  = 2'd2,
    StCommit = 2'd3
  } state_e;

  // Size writes: 0 becomes 1, anything beyond the visible extent saturates.
  function automatic logic [9:0] clamp_size(input logic [9:0] v, input logic [10:0] lim);
    if (v == 10'd0) return 10'd1;
    if ({1'b0, v} > lim) return lim[9:0];
    return v;
  endfunction

  // Position writes keep the whole box on screen for the current size.
  function automatic logic [9:0] clamp_pos(input logic [9:0] v, input logic [9:0] size,
                                           input logic [10:0] lim);
    logic [10:0] max_pos;
    max_pos = lim - {1'b0, size};
    if ({1'b0, v} > max_pos) return max_pos[9:0];
    return v;
  endfunction

endpackage

// File: rtl/rect_motion_ctrl_axis_step.sv
// One axis of the bounce motion: advances the position by step in the current
// direction and reflects off 0 or limit.
module rect_motion_ctrl_axis_step (
  input  logic [9:0]  pos,
  input  logic [9:0]  size,
  input  logic [3:0]  step,
  input  logic        dir,
  input  logic [10:0] limit,
  output logic [9:0]  pos_next,
  output logic        dir_next
);

  logic [10:0] far_edge;
  logic [9:0]  step_ext;

  assign step_ext = {6'd0, step};
  assign far_edge = {1'b0, pos} + {1'b0, size} + {7'd0, step};

  always_comb begin
    pos_next = pos;
    dir_next = dir;
    // A zero step freezes the axis, including its direction.
    if (step != 4'd0) begin
      if (dir) begin
        if (far_edge > limit) begin
          pos_next = 10'(limit - {1'b0, size});
          dir_next = 1'b0;
        end else begin
          pos_next = pos + step_ext;
        end
      end else begin
        if (pos < step_ext) begin
          pos_next = 10'd0;
          dir_next = 1'b1;
        end else begin
          pos_next = pos - step_ext;
        end
      end
    end
  end

endmodule

// File: rtl/rect_motion_ctrl.sv
// Frame-synchronous bouncing-box geometry controller: steps the box once per
// frame at the start of vertical blanking and commits it to shadow outputs.
module rect_motion_ctrl
  import rect_motion_ctrl_pkg::*;
#(
  parameter int unsigned H_ACTIVE = HActiveDef,
  parameter int unsigned V_ACTIVE = VActiveDef,
  parameter int unsigned X_INIT   = 0,
  parameter int unsigned Y_INIT   = 0,
  parameter int unsigned W_INIT   = 32,
  parameter int unsigned H_INIT   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        enable,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_addr,
  input  logic [19:0] cfg_data,
  output logic [9:0]  x0,
  output logic [9:0]  y0,
  output logic [9:0]  w,
  output logic [9:0]  h,
  output logic        frame_done
);

  localparam logic [10:0] HLim  = 11'(H_ACTIVE);
  localparam logic [10:0] VLim  = 11'(V_ACTIVE);
  localparam logic [9:0]  VLine = 10'(V_ACTIVE);

  state_e state_q, state_d;

  logic [9:0] wk_x_q, wk_x_d, wk_y_q, wk_y_d, wk_w_q, wk_w_d, wk_h_q, wk_h_d;
  logic [3:0] dx_q, dx_d, dy_q, dy_d;
  logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [9:0] x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic       frame_done_q, frame_done_d;

  logic       frame_tick;
  logic       cfg_fire;
  logic [9:0] x_step, y_step;
  logic       dir_x_step, dir_y_step;

  assign frame_tick = enable && (state_q == StIdle) && (x == 10'd0) && (y == VLine);
  assign cfg_fire   = cfg_valid && cfg_ready;

  rect_motion_ctrl_axis_step u_step_x (
    .pos      (wk_x_q),
    .size     (wk_w_q),
    .step     (dx_q),
    .dir      (dir_x_q),
    .limit    (HLim),
    .pos_next (x_step),
    .dir_next (dir_x_step)
  );

  rect_motion_ctrl_axis_step u_step_y (
    .pos      (wk_y_q),
    .size     (wk_h_q),
    .step     (dy_q),
    .dir      (dir_y_q),
    .limit    (VLim),
    .pos_next (y_step),
    .dir_next (dir_y_step)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (frame_tick) state_d = StMoveX;
      StMoveX:  state_d = StMoveY;
      StMoveY:  state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    cfg_ready = (state_q == StIdle);
  end

  // Datapath next state; config writes and motion steps never share a state.
  always_comb begin
    wk_x_d       = wk_x_q;
    wk_y_d       = wk_y_q;
    wk_w_d       = wk_w_q;
    wk_h_d       = wk_h_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = dir_y_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    w_d          = w_q;
    h_d          = h_q;
    frame_done_d = 1'b0;

    if (cfg_fire) begin
      unique case (cfg_addr_e'(cfg_addr))
        CfgW:     wk_w_d = clamp_size(cfg_data[9:0], HLim);
        CfgH:     wk_h_d = clamp_size(cfg_data[9:0], VLim);
        CfgSpeed: begin
          dx_d = cfg_data[3:0];
          dy_d = cfg_data[7:4];
        end
        CfgPos:   begin
          wk_x_d = clamp_pos(cfg_data[9:0], wk_w_q, HLim);
          wk_y_d = clamp_pos(cfg_data[19:10], wk_h_q, VLim);
        end
        default:  ;
      endcase
    end

    unique case (state_q)
      StMoveX: begin
        wk_x_d  = x_step;
        dir_x_d = dir_x_step;
      end
      StMoveY: begin
        wk_y_d  = y_step;
        dir_y_d = dir_y_step;
      end
      StCommit: begin
        x0_d         = wk_x_q;
        y0_d         = wk_y_q;
        w_d          = wk_w_q;
        h_d          = wk_h_q;
        frame_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wk_x_q       <= 10'(X_INIT);
      wk_y_q       <= 10'(Y_INIT);
      wk_w_q       <= 10'(W_INIT);
      wk_h_q       <= 10'(H_INIT);
      dx_q         <= 4'd1;
      dy_q         <= 4'd1;
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      x0_q         <= 10'(X_INIT);
      y0_q         <= 10'(Y_INIT);
      w_q          <= 10'(W_INIT);
      h_q          <= 10'(H_INIT);
      frame_done_q <= 1'b0;
    end else begin
      wk_x_q       <= wk_x_d;
      wk_y_q       <= wk_y_d;
      wk_w_q       <= wk_w_d;
      wk_h_q       <= wk_h_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      w_q          <= w_d;
      h_q          <= h_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign x0         = x0_q;
  assign y0         = y0_q;
  assign w          = w_q;
  assign h          = h_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/rect_motion_ctrl.md
# rect_motion_ctrl

Frame-synchronous controller that owns the geometry (x0, y0, w, h) driven into the VGA rectangle renderer and animates it as a bouncing box. Position updates happen once per frame, during vertical blanking, so the renderer never draws a torn rectangle. A valid/ready configuration port lets the system logic change size and speed at run time. The block sits between the sync generator's pixel counters and the rectangle renderer.

## Interface
- H_ACTIVE, 640: visible width in pixels.
- V_ACTIVE, 480: visible height in lines.
- X_INIT, 0: reset x0.
- Y_INIT, 0: reset y0.
- W_INIT, 32: reset width.
- H_INIT, 32: reset height.

- clk  in  1  pixel clock; only clock.
- rst  in  1  synchronous, active-high reset.
- x  in  10  horizontal pixel counter, 0–799.
- y  in  10  vertical line counter, 0–524.
- enable  in  1  motion enable; 0 freezes position.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  controller can accept a write.
- cfg_addr  in  2  0 = w, 1 = h, 2 = speed, 3 = position.
- cfg_data  in  20  write payload. w/h use [9:0]; speed uses [3:0] = dx and [7:4] = dy; position uses [9:0] = x0 and [19:10] = y0.
- x0, y0, w, h  out  10 each  registered geometry to the renderer.
- frame_done  out  1  one-cycle pulse when new geometry is committed.

## Operation
- **Frame tick:** asserted in the single cycle where x == 0 and y == V_ACTIVE, i.e. the first pixel of vertical blanking. It is ignored when enable = 0, or while the FSM is not IDLE.
- **Working registers:** wk_x, wk_y, wk_w, wk_h, dx, dy, dir_x, dir_y (1 = increasing). Outputs x0/y0/w/h are shadow copies loaded only in COMMIT.
- **FSM states:** IDLE → MOVE_X → MOVE_Y → COMMIT → IDLE. Each state lasts exactly one cycle.
- **MOVE_X, dir_x = 1:** if wk_x + wk_w + dx > H_ACTIVE, then wk_x = H_ACTIVE − wk_w and dir_x = 0. Otherwise wk_x += dx.
- **MOVE_X, dir_x = 0:** if wk_x < dx, then wk_x = 0 and dir_x = 1. Otherwise wk_x −= dx.
- **MOVE_Y:** same rules as MOVE_X, using V_ACTIVE, wk_h, dy and dir_y.
- **Arithmetic width:** all comparisons are 11-bit, so there is no wrap-around.
- **dx = 0 or dy = 0:** that axis holds its position and its direction never flips.
- **COMMIT:** copy working registers to the outputs and pulse frame_done.
- **cfg_ready:** equals 1 only in IDLE. A write is accepted on a cycle where cfg_valid && cfg_ready and updates the working register at that edge.
- **w/h writes:** clamped to the range 1..H_ACTIVE (w) or 1..V_ACTIVE (h). A value of 0 becomes 1.
- **Position writes:** clamped so that x0 + w ≤ H_ACTIVE and y0 + h ≤ V_ACTIVE.
- **Write in the same cycle as a frame tick:** the write is accepted, and the move uses the new value.
- **Visibility of writes:** a write becomes visible on the outputs only at the next COMMIT, including when enable = 0. While enable = 0, writes are held until enable returns and a frame is processed.

## Timing
- **Reset values:**
  - x0 = X_INIT, y0 = Y_INIT, w = W_INIT, h = H_INIT.
  - Working registers mirror the outputs.
  - dx = dy = 1; dir_x = dir_y = 1.
  - cfg_ready = 1, frame_done = 0, state = IDLE.
- **Latency:** frame tick at cycle T → MOVE_X at T+1 → MOVE_Y at T+2 → COMMIT at T+3. Outputs and frame_done change at the T+4 edge and remain stable for the whole next active frame.
- **cfg_ready:** low from T+1 through T+3 inclusive. A cfg_valid held during that window is accepted at the first IDLE cycle.
- **Reset mid-sequence:** returns to IDLE with reset values next cycle. No partial commit occurs.

## Structure
- Shared include vga_params holds H_ACTIVE/V_ACTIVE defaults, the total line and frame counts (800/525), the cfg_addr codes, and the state encodings.
- One sub-module: axis_step. It is combinational and handles one axis: inputs pos, size, step, dir, limit; outputs next pos and next dir. It is instantiated twice, once for X and once for Y.

## Test plan
- **Reset:** assert rst for 2 cycles → x0 = 0, y0 = 0, w = 32, h = 32, cfg_ready = 1, frame_done = 0.
- **Normal step:** enable = 1, dx = 4, dy = 2, start at (0,0); run 3 frames → x0/y0 = (4,2), (8,4), (12,6). frame_done is asserted exactly 4 cycles after each (0,480) tick.
- **Right-edge bounce:** x0 = 606, w = 32, dx = 4 → next frames give x0 = 608 (dir_x = 0), then 604.
- **Left-edge bounce:** x0 = 2, dir_x = 0, dx = 4 → x0 = 0, dir_x = 1, then x0 = 4.
- **Config handshake:** hold cfg_valid with w = 700 across a tick → not accepted during the 3 busy cycles; accepted in the first IDLE cycle; w reads 640 after the next commit. Separately, writing w = 0 → w reads 1.
- **Freeze and mid-sequence reset:** enable = 0 for 2 frames → outputs unchanged and no frame_done. Asserting rst in MOVE_Y → next cycle is IDLE with reset values, and frame_done never pulses.
